// File: rtl/booth8_seq_mul.sv
// Iterative 16x16 signed multiplier: walks the multiplier in radix-8 Booth groups,
// feeding an external partial-product generator and accumulating one group per cycle.
module booth8_seq_mul #(
    parameter int PP_WIDTH   = 19,
    parameter int PROD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           a_in,
    input  logic [15:0]           b_in,
    output logic                  busy,
    output logic                  done,
    output logic [PROD_WIDTH-1:0] product,
    output logic [15:0]           pp_a,
    output logic [3:0]            pp_sel,
    input  logic [PP_WIDTH-1:0]   pp_in,
    input  logic                  pp_sign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [2:0]              count;
    logic [17:0]             breg;
    logic [PROD_WIDTH-1:0]   acc;
    logic [PROD_WIDTH-1:0]   acc_sum;
    logic [18:0]             b_ext;
    logic [3:0]              window;
    logic [3:0]              booth_sel;
    logic [PROD_WIDTH-1:0]   pp_ext;
    logic [PROD_WIDTH-1:0]   term;
    logic [4:0]              shift_amt;

    // Implicit zero below the LSB so group 0 sees breg[-1] = 0.
    assign b_ext = {breg, 1'b0};

    always_comb begin
        window = 4'b0000;
        case (count)
            3'd0:    window = b_ext[3:0];
            3'd1:    window = b_ext[6:3];
            3'd2:    window = b_ext[9:6];
            3'd3:    window = b_ext[12:9];
            3'd4:    window = b_ext[15:12];
            3'd5:    window = b_ext[18:15];
            default: window = 4'b0000;
        endcase
    end

    // Digit = -4*w3 + 2*w2 + w1 + w0, encoded as {negative, magnitude}; zero is never negative.
    always_comb begin
        booth_sel = 4'b0000;
        case (window)
            4'b0000: booth_sel = 4'b0000;
            4'b0001: booth_sel = 4'b0001;
            4'b0010: booth_sel = 4'b0001;
            4'b0011: booth_sel = 4'b0010;
            4'b0100: booth_sel = 4'b0010;
            4'b0101: booth_sel = 4'b0011;
            4'b0110: booth_sel = 4'b0011;
            4'b0111: booth_sel = 4'b0100;
            4'b1000: booth_sel = 4'b1100;
            4'b1001: booth_sel = 4'b1011;
            4'b1010: booth_sel = 4'b1011;
            4'b1011: booth_sel = 4'b1010;
            4'b1100: booth_sel = 4'b1010;
            4'b1101: booth_sel = 4'b1001;
            4'b1110: booth_sel = 4'b1001;
            4'b1111: booth_sel = 4'b0000;
            default: booth_sel = 4'b0000;
        endcase
    end

    always_comb begin
        pp_ext    = {{(PROD_WIDTH-PP_WIDTH){pp_in[PP_WIDTH-1]}}, pp_in};
        term      = pp_sign ? (~pp_ext + 1'b1) : pp_ext;
        shift_amt = {2'b00, count} * 5'd3;
        acc_sum   = acc + (term << shift_amt);
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pp_sel     = 4'b0000;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy   = 1'b1;
                pp_sel = booth_sel;
                if (count == 3'd5) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Product is only overwritten by a completed multiply, so it stays put while idle or busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= 3'd0;
            breg    <= 18'd0;
            acc     <= '0;
            product <= '0;
            pp_a    <= 16'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        pp_a  <= a_in;
                        breg  <= {{2{b_in[15]}}, b_in};
                        acc   <= '0;
                        count <= 3'd0;
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    count <= count + 3'd1;
                    if (count == 3'd5) begin
                        product <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth8_seq_mul.sv
// Self-checking bench for booth8_seq_mul; models the partial-product generator and
// checks products against plain signed multiplication.
module tb_booth8_seq_mul;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [15:0] pp_a;
    logic [3:0]  pp_sel;
    logic [18:0] pp_in;
    logic        pp_sign;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] sels[$];

    booth8_seq_mul #(.PP_WIDTH(19), .PROD_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .product(product), .pp_a(pp_a),
        .pp_sel(pp_sel), .pp_in(pp_in), .pp_sign(pp_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generator stand-in: magnitude times multiplicand, negation left to the consumer.
    always_comb begin
        pp_in   = 19'(int'($signed(pp_a)) * int'(pp_sel[2:0]));
        pp_sign = pp_sel[3];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launches one multiply and records what the DUT shows over the following 8 cycles.
    task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] prod, output int done_k,
                          output int busy_cycles, output int done_pulses);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        sels.delete();
        done_k      = -1;
        busy_cycles = 0;
        done_pulses = 0;
        prod        = 32'hxxxx_xxxx;
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1) busy_cycles++;
            if (busy === 1'b1 && done !== 1'b1) sels.push_back(pp_sel);
            if (done === 1'b1) begin
                done_pulses++;
                if (done_k < 0) begin
                    done_k = k;
                    prod   = product;
                end
            end
            if (k < 7) step();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 16'h1234;
        b_in  = 16'h5678;
        step();
        step();
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (product !== 32'h0) $display("[TB] FAIL reset_product: got %h want 0", product); else n_pass++;
        n_checks++; if (pp_a !== 16'h0) $display("[TB] FAIL reset_pp_a: got %h want 0", pp_a); else n_pass++;
        n_checks++; if (pp_sel !== 4'h0) $display("[TB] FAIL reset_pp_sel: got %b want 0000", pp_sel); else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] prod;
        int done_k, busy_cycles, done_pulses;
        do_mul(16'd3, 16'd5, prod, done_k, busy_cycles, done_pulses);
        n_checks++; if (busy_cycles !== 7) $display("[TB] FAIL basic_busy_len: got %0d want 7", busy_cycles); else n_pass++;
        n_checks++; if (done_pulses !== 1) $display("[TB] FAIL basic_done_pulses: got %0d want 1", done_pulses); else n_pass++;
        n_checks++; if (done_k !== 6) $display("[TB] FAIL basic_latency: done at %0d want 6", done_k); else n_pass++;
        n_checks++; if (prod !== 32'h0000_000F) $display("[TB] FAIL basic_product: got %h want 0000000f", prod); else n_pass++;
        for (int i = 0; i < 3; i++) step();
        n_checks++; if (product !== 32'h0000_000F) $display("[TB] FAIL basic_hold: got %h want 0000000f", product); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL basic_idle_done: got %b want 0", done); else n_pass++;
    endtask

    task automatic test_corners();
        logic [15:0] ca[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        logic [15:0] cb[4] = '{16'h8000, 16'h8000, 16'h0001, 16'h1234};
        logic [31:0] ce[4] = '{32'h4000_0000, 32'hC000_8000, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] prod;
        int done_k, busy_cycles, done_pulses;
        bit neg_zero;
        for (int i = 0; i < 4; i++) begin
            do_mul(ca[i], cb[i], prod, done_k, busy_cycles, done_pulses);
            neg_zero = 1'b0;
            foreach (sels[j]) if (sels[j] == 4'b1000) neg_zero = 1'b1;
            n_checks++; if (prod !== ce[i]) $display("[TB] FAIL corner_product[%0d]: got %h want %h", i, prod, ce[i]); else n_pass++;
            n_checks++; if (done_k !== 6) $display("[TB] FAIL corner_latency[%0d]: done at %0d want 6", i, done_k); else n_pass++;
            n_checks++; if (neg_zero) $display("[TB] FAIL corner_neg_zero[%0d]: got sel 1000 want none", i); else n_pass++;
        end
    endtask

    task automatic test_booth_select();
        logic [3:0]  exp_sel[6] = '{4'b1100, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [15:0] a;
        logic [31:0] prod;
        int done_k, busy_cycles, done_pulses;
        a = 16'($urandom);
        do_mul(a, 16'h0004, prod, done_k, busy_cycles, done_pulses);
        n_checks++; if (sels.size() != 6) $display("[TB] FAIL sel_count: got %0d want 6", sels.size()); else n_pass++;
        for (int i = 0; i < 6 && i < sels.size(); i++) begin
            n_checks++;
            if (sels[i] !== exp_sel[i]) $display("[TB] FAIL sel_seq[%0d]: got %b want %b", i, sels[i], exp_sel[i]);
            else n_pass++;
        end
        n_checks++;
        if (prod !== 32'(int'($signed(a)) * 4)) $display("[TB] FAIL sel_product: got %h want %h", prod, 32'(int'($signed(a)) * 4));
        else n_pass++;
    endtask

    task automatic test_start_ignored_and_abort();
        logic [31:0] prod;
        int done_k, done_seen, busy_seen;
        a_in  = 16'd100;
        b_in  = 16'hFFF9;
        start = 1'b1;
        step();
        done_k = -1;
        prod   = 32'hxxxx_xxxx;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1 && done_k < 0) begin
                done_k = k;
                prod   = product;
            end
            if (k == 4) begin
                n_checks++; if (pp_a !== 16'd100) $display("[TB] FAIL ignore_pp_a: got %h want 0064", pp_a); else n_pass++;
            end
            if (k == 2) begin
                a_in  = 16'h4321;
                b_in  = 16'h0777;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k < 7) step();
        end
        n_checks++; if (done_k !== 6) $display("[TB] FAIL ignore_latency: done at %0d want 6", done_k); else n_pass++;
        n_checks++; if (prod !== 32'hFFFF_FD44) $display("[TB] FAIL ignore_product: got %h want fffffd44", prod); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL ignore_no_restart: busy %b want 0", busy); else n_pass++;

        a_in  = 16'd1234;
        b_in  = 16'd567;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b want 0", done); else n_pass++;
        n_checks++; if (product !== 32'h0) $display("[TB] FAIL abort_product: got %h want 0", product); else n_pass++;
        done_seen = 0;
        busy_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        n_checks++; if (done_seen != 0) $display("[TB] FAIL abort_no_done: got %0d pulses want 0", done_seen); else n_pass++;
        n_checks++; if (busy_seen != 0) $display("[TB] FAIL abort_stays_idle: busy %0d cycles want 0", busy_seen); else n_pass++;
    endtask

    task automatic test_back_to_back();
        localparam int N = 1500;
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [15:0] a, b;
        int ndone, last_done, exp_val, sum, weight, mag;
        bit digits_ok;
        ndone     = 0;
        last_done = -1;
        start     = 1'b1;
        for (int cyc = 0; cyc < N * 8 + 40 && ndone < N; cyc++) begin
            if (busy === 1'b0 && done === 1'b0) begin
                a = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
                b = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
                a_in = a;
                b_in = b;
                qa.push_back(a);
                qb.push_back(b);
                sels.delete();
            end else if (busy === 1'b1 && done !== 1'b1) begin
                sels.push_back(pp_sel);
            end else if (done === 1'b1) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    $display("[TB] FAIL b2b_spurious_done: got done at cycle %0d want none", cyc);
                end else begin
                    a = qa.pop_front();
                    b = qb.pop_front();
                    exp_val = int'($signed(a)) * int'($signed(b));
                    n_checks++;
                    if (product !== 32'(exp_val))
                        $display("[TB] FAIL b2b_product: a=%h b=%h got %h want %h", a, b, product, 32'(exp_val));
                    else n_pass++;
                    sum       = 0;
                    weight    = 1;
                    digits_ok = (sels.size() == 6);
                    foreach (sels[i]) begin
                        mag = int'(sels[i][2:0]);
                        if (mag > 4 || sels[i] == 4'b1000) digits_ok = 1'b0;
                        sum    += (sels[i][3] ? -mag : mag) * weight;
                        weight *= 8;
                    end
                    n_checks++;
                    if (!digits_ok || sum != int'($signed(b)))
                        $display("[TB] FAIL b2b_booth_digits: b=%h got sum %0d over %0d digits want %0d over 6", b, sum, sels.size(), int'($signed(b)));
                    else n_pass++;
                    if (last_done >= 0) begin
                        n_checks++;
                        if (cyc - last_done != 8) $display("[TB] FAIL b2b_spacing: got %0d want 8", cyc - last_done);
                        else n_pass++;
                    end
                    last_done = cyc;
                    ndone++;
                end
            end
            if (ndone < N) step();
        end
        start = 1'b0;
        n_checks++; if (ndone != N) $display("[TB] FAIL b2b_completed: got %0d want %0d", ndone, N); else n_pass++;
        step();
        step();
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        a_in  = 16'h0;
        b_in  = 16'h0;
        #2;
        test_reset();
        test_basic();
        test_corners();
        test_booth_select();
        test_start_ignored_and_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
